// File: rtl/alu_pkg.sv
// Shared widths and helpers for the multiply-accumulate ALU.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 39;
  localparam int unsigned PROD_W = 2 * DATA_W;

  // Two's-complement add overflow from the addend and sum sign bits.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

// File: rtl/alu_mul.sv
// Combinational full-width signed multiplier: DATA_W x DATA_W -> PROD_W.
module alu_mul #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W,
  parameter int unsigned PROD_W = alu_pkg::PROD_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [PROD_W-1:0] p
);

  // Operands are sign-extended to the product width so no bits are lost.
  assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/alu.sv
// Signed MAC: combinational totalSumIn + inputX*inputB, plus an accumulator
// register with a sticky signed-overflow flag. ACC_W must be >= 2*DATA_W+1.
module alu #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W,
  parameter int unsigned ACC_W  = alu_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] inputX,
  input  logic signed [DATA_W-1:0] inputB,
  input  logic signed [ACC_W-1:0]  totalSumIn,
  output logic signed [ACC_W-1:0]  totalSumOut,
  input  logic                     accEn,
  input  logic                     accClr,
  output logic signed [ACC_W-1:0]  accOut,
  output logic                     ovf
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  import alu_pkg::*;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic                     sum_ovf;

  alu_mul #(
    .DATA_W(DATA_W),
    .PROD_W(PROD_W)
  ) u_mul (
    .a(inputX),
    .b(inputB),
    .p(prod)
  );

  // Sum wraps modulo 2^ACC_W; overflow is only flagged, never saturated.
  assign prod_ext    = ACC_W'(prod);
  assign totalSumOut = totalSumIn + prod_ext;
  assign sum_ovf     = add_ovf(totalSumIn[ACC_W-1], prod_ext[ACC_W-1], totalSumOut[ACC_W-1]);

  // Clear wins over load; idle cycles hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accOut <= '0;
      ovf    <= 1'b0;
    end else if (accClr) begin
      accOut <= '0;
      ovf    <= 1'b0;
    end else if (accEn) begin
      accOut <= totalSumOut;
      ovf    <= ovf | sum_ovf;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expectations, a monitor compares.
module tb_alu;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 39;

  logic                 clk;
  logic                 rst;
  logic signed [DW-1:0] x;
  logic signed [DW-1:0] b;
  logic signed [AW-1:0] tsi;
  logic signed [AW-1:0] tso;
  logic                 acc_en;
  logic                 acc_clr;
  logic signed [AW-1:0] acc_out;
  logic                 ovf;

  alu #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .inputX(x),
    .inputB(b),
    .totalSumIn(tsi),
    .totalSumOut(tso),
    .accEn(acc_en),
    .accClr(acc_clr),
    .accOut(acc_out),
    .ovf(ovf)
  );

  typedef struct {
    string                name;
    bit                   chk_sum;
    logic signed [AW-1:0] sum;
    bit                   chk_acc;
    logic signed [AW-1:0] acc;
    bit                   ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic signed [AW-1:0] acc_m;
  bit                   ovf_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: exact integer arithmetic, then reduce to AW bits.
  function automatic longint exact_sum(input logic signed [DW-1:0] xv,
                                       input logic signed [DW-1:0] bv,
                                       input logic signed [AW-1:0] iv);
    return longint'(iv) + longint'(xv) * longint'(bv);
  endfunction

  function automatic logic signed [AW-1:0] ref_sum(input logic signed [DW-1:0] xv,
                                                   input logic signed [DW-1:0] bv,
                                                   input logic signed [AW-1:0] iv);
    longint s;
    s = exact_sum(xv, bv, iv);
    return s[AW-1:0];
  endfunction

  function automatic bit ref_ovf(input logic signed [DW-1:0] xv,
                                 input logic signed [DW-1:0] bv,
                                 input logic signed [AW-1:0] iv);
    longint s;
    longint lim;
    s   = exact_sum(xv, bv, iv);
    lim = longint'(1) <<< (AW - 1);
    return (s >= lim) || (s < -lim);
  endfunction

  task automatic push(input string n, input bit cs, input logic signed [AW-1:0] s,
                      input bit ca, input logic signed [AW-1:0] a, input bit o);
    exp_t e;
    e.name = n; e.chk_sum = cs; e.sum = s; e.chk_acc = ca; e.acc = a; e.ovf = o;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_sum_const(input string n, input logic signed [AW-1:0] v);
    #1;
    push(n, 1'b1, v, 1'b0, '0, 1'b0);
  endtask

  task automatic check_sum_ref(input string n);
    #1;
    push(n, 1'b1, ref_sum(x, b, tsi), 1'b0, '0, 1'b0);
  endtask

  // One clock with the given controls; the model advances alongside.
  task automatic clock_step(input string n, input bit en_v, input bit clr_v);
    @(negedge clk);
    acc_en  = en_v;
    acc_clr = clr_v;
    if (clr_v) begin
      acc_m = '0;
      ovf_m = 1'b0;
    end else if (en_v) begin
      ovf_m = ovf_m | ref_ovf(x, b, tsi);
      acc_m = ref_sum(x, b, tsi);
    end
    @(posedge clk);
    #1;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    push(n, 1'b1, ref_sum(x, b, tsi), 1'b1, acc_m, ovf_m);
  endtask

  // Monitor: pops each expectation and compares it against the live outputs.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      if (e.chk_sum) begin
        n_cmp++;
        if (tso !== e.sum) begin
          n_fail++;
          $display("FAIL %s totalSumOut: got %0d want %0d", e.name, tso, e.sum);
        end
      end
      if (e.chk_acc) begin
        n_cmp++;
        if (acc_out !== e.acc) begin
          n_fail++;
          $display("FAIL %s accOut: got %0d want %0d", e.name, acc_out, e.acc);
        end
        n_cmp++;
        if (ovf !== e.ovf) begin
          n_fail++;
          $display("FAIL %s ovf: got %0b want %0b", e.name, ovf, e.ovf);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [AW-1:0] max_pos;
    logic signed [AW-1:0] min_neg;
    logic signed [AW-1:0] pre_sum;
    max_pos = {1'b0, {(AW-1){1'b1}}};
    min_neg = {1'b1, {(AW-1){1'b0}}};

    rst = 1'b1; x = '0; b = '0; tsi = '0; acc_en = 1'b0; acc_clr = 1'b0;
    acc_m = '0; ovf_m = 1'b0;
    #2;
    push("reset_state", 1'b1, '0, 1'b1, '0, 1'b0);

    // Load requested while reset held must be ignored.
    x = 16'sd3; b = 16'sd4; acc_en = 1'b1;
    @(posedge clk);
    #1;
    acc_en = 1'b0;
    push("reset_hold_edge", 1'b1, 39'sd12, 1'b1, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    x = 16'sd3; b = -16'sd4; tsi = 39'sd100;
    check_sum_const("comb_3x-4+100", 39'sd88);
    x = -16'sd32768; b = -16'sd32768; tsi = '0;
    check_sum_const("comb_minxmin", 39'sd1073741824);
    x = 16'sd1; b = 16'sd1; tsi = max_pos;
    check_sum_const("comb_wrap", min_neg);
    clock_step("acc_wrap_ovf", 1'b1, 1'b0);
    push("acc_wrap_const", 1'b0, '0, 1'b1, min_neg, 1'b1);

    // Overflow stays sticky through a clean load.
    x = 16'sd2; b = 16'sd2; tsi = 39'sd5;
    clock_step("ovf_sticky", 1'b1, 1'b0);
    clock_step("hold_idle", 1'b0, 1'b0);

    // Asynchronous reset between edges.
    x = 16'sd7; b = 16'sd9; tsi = acc_m;
    clock_step("pre_rst_acc", 1'b1, 1'b0);
    @(posedge clk);
    #3;
    pre_sum = ref_sum(x, b, tsi);
    rst = 1'b1;
    acc_m = '0; ovf_m = 1'b0;
    #1;
    push("rst_async", 1'b1, pre_sum, 1'b1, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    clock_step("post_rst_first", 1'b1, 1'b0);

    // Running accumulation with the partial sum fed back.
    clock_step("clr_before_run", 1'b0, 1'b1);
    x = 16'sd2; b = 16'sd5;
    for (int i = 1; i <= 3; i++) begin
      tsi = acc_m;
      clock_step("run_step", 1'b1, 1'b0);
      push("run_const", 1'b0, '0, 1'b1, 39'(10 * i), 1'b0);
    end
    clock_step("clr_priority", 1'b1, 1'b1);

    for (int i = 0; i < 100; i++) begin
      x   = 16'($urandom);
      b   = 16'($urandom);
      tsi = {16'($urandom), 16'($urandom), 7'b0};
      check_sum_ref("rand_comb");
    end

    for (int i = 0; i < 40; i++) begin
      x   = 16'($urandom);
      b   = 16'($urandom);
      tsi = ($urandom_range(0, 1) == 0) ? acc_m : AW'({$urandom, $urandom});
      clock_step("rand_acc", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    end

    #5;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
